// File: rtl/ntt_pkg.sv
// Shared constants and types for the 256-point NTT/INTT sequencer.
package ntt_pkg;

  localparam int N          = 256;
  localparam int LOG_N      = 8;
  localparam int NUM_LAYERS = 7;
  localparam int KYBER_Q    = 3329;

  typedef logic [LOG_N-1:0] coef_addr_t;
  typedef logic [LOG_N-2:0] tw_idx_t;
  typedef logic [LOG_N-2:0] pair_t;
  typedef logic [2:0]       layer_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address and twiddle index generator.
// Maps (pair p, layer, direction) to the in-place pair (j, j+len) and ROM index k.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  pair_t      pair_i,
  input  layer_t     layer_i,
  input  logic       intt_i,
  output coef_addr_t addr_a_o,
  output coef_addr_t addr_b_o,
  output tw_idx_t    tw_idx_o
);

  logic [2:0] shift;
  logic [2:0] shift_m1;
  logic [7:0] len;
  logic [6:0] mask;
  logic [6:0] grp;
  logic [6:0] ofs;
  logic [7:0] base;

  always_comb begin
    // NTT walks len = 128..2, INTT walks len = 2..128; shift is log2(len), always >= 1
    shift    = intt_i ? (layer_i + 3'd1) : (3'd7 - layer_i);
    shift_m1 = shift - 3'd1;
    len      = 8'd1 << shift;
    mask     = 7'h7f >> (3'd7 - shift);
    grp      = pair_i >> shift;
    ofs      = pair_i & mask;
    base     = ({1'b0, grp} << ({1'b0, shift} + 4'd1)) | {1'b0, ofs};
    addr_a_o = base;
    addr_b_o = base + len;
    // 128>>s == 64>>(s-1) and (256>>s)-1 == 127>>(s-1), keeping the math in 7 bits
    if (intt_i) tw_idx_o = (7'h7f >> shift_m1) - grp;
    else        tw_idx_o = (7'h40 >> shift_m1) + grp;
  end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT sequencer: issues one butterfly pair per cycle to the BFU and
// writes results back in place through a read+BFU latency-matched delay line.
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | one pair per cycle, p = 0..127 of the current layer
// DRAIN | RD_LAT+BFU_LAT cycles so the layer's last write lands before the next read
// DONE  | one-cycle o_done pulse, start requests ignored
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int BFU_LAT = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_intt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr_a,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output tw_idx_t           o_tw_idx,
  output logic              o_bfu_intt,
  output logic              o_bfu_skip,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr_a,
  output logic [ADDR_W-1:0] o_wr_addr_b
);

  localparam int DRAIN_CYC = RD_LAT + BFU_LAT;
  localparam int CNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int DLY_W     = 2 * ADDR_W + 1;

  state_t           state_q, state_d;
  pair_t            pair_q, pair_d;
  layer_t           layer_q, layer_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             intt_q, intt_d;
  logic             issue_d;

  coef_addr_t       gen_a, gen_b;
  tw_idx_t          gen_tw;

  logic [DLY_W-1:0] dly_q [DRAIN_CYC];

  // Addresses are generated for the next pair so the read outputs can be registered
  ntt_addr_gen u_addr_gen (
    .pair_i   (pair_d),
    .layer_i  (layer_d),
    .intt_i   (intt_d),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    layer_d = layer_q;
    drain_d = drain_q;
    intt_d  = intt_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ISSUE;
          pair_d  = '0;
          layer_d = '0;
          intt_d  = i_intt;
        end
      end
      ISSUE: begin
        if (pair_q == pair_t'(N / 2 - 1)) begin
          state_d = DRAIN;
          drain_d = CNT_W'(DRAIN_CYC - 1);
        end else begin
          pair_d = pair_q + pair_t'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          if (layer_q == layer_t'(NUM_LAYERS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            layer_d = layer_q + layer_t'(1);
            pair_d  = '0;
          end
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    issue_d = (state_d == ISSUE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pair_q      <= '0;
      layer_q     <= '0;
      drain_q     <= '0;
      intt_q      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_idx    <= '0;
      for (int i = 0; i < DRAIN_CYC; i++) dly_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pair_q      <= pair_d;
      layer_q     <= layer_d;
      drain_q     <= drain_d;
      intt_q      <= intt_d;
      o_busy      <= (state_d != IDLE);
      o_done      <= (state_d == DONE);
      o_rd_en     <= issue_d;
      o_rd_addr_a <= issue_d ? gen_a  : '0;
      o_rd_addr_b <= issue_d ? gen_b  : '0;
      o_tw_idx    <= issue_d ? gen_tw : '0;
      dly_q[0]    <= {o_rd_en, o_rd_addr_a, o_rd_addr_b};
      for (int i = 1; i < DRAIN_CYC; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = dly_q[DRAIN_CYC-1];
  assign o_bfu_intt = intt_q;
  assign o_bfu_skip = 1'b0;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: pair order against a Kyber-style loop model,
// write-back alignment, run length, start/intt filtering and async reset.
module tb_ntt_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_intt;
  logic       o_busy;
  logic       o_done;
  logic       o_rd_en;
  logic [7:0] o_rd_addr_a;
  logic [7:0] o_rd_addr_b;
  logic [6:0] o_tw_idx;
  logic       o_bfu_intt;
  logic       o_bfu_skip;
  logic       o_wr_en;
  logic [7:0] o_wr_addr_a;
  logic [7:0] o_wr_addr_b;

  ntt_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_intt      (i_intt),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .o_tw_idx    (o_tw_idx),
    .o_bfu_intt  (o_bfu_intt),
    .o_bfu_skip  (o_bfu_skip),
    .o_wr_en     (o_wr_en),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b)
  );

  localparam int NPAIR   = 896;
  localparam int WR_DLY  = 5;
  localparam int DONE_AT = 931;
  localparam int BUSY_N  = 932;

  typedef struct {
    int cyc;
    int a;
    int b;
  } wr_rec_t;

  int err_cnt = 0;
  int chk_cnt = 0;

  int ea [2][NPAIR];
  int eb [2][NPAIR];
  int ek [2][NPAIR];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Reference pair order in the classic nested-loop form (groups, then butterflies)
  task automatic build_model();
    int idx, k, kk;
    idx = 0;
    k = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ea[0][idx] = j; eb[0][idx] = j + len; ek[0][idx] = k;
          idx++;
        end
        k++;
      end
    end
    idx = 0;
    k = 127;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        kk = k;
        k--;
        for (int j = st; j < st + len; j++) begin
          ea[1][idx] = j; eb[1][idx] = j + len; ek[1][idx] = kk;
          idx++;
        end
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the sample point after o_done.
  task automatic run_op(input logic intt, input bit disturb, input string nm);
    int busy_n, iss, wr, seq_err, wr_err, bfu_err, done_cyc, first_cyc, m;
    int ca [NPAIR];
    int cb [NPAIR];
    int ck [NPAIR];
    wr_rec_t wq[$];
    wr_rec_t r;
    busy_n = 0; iss = 0; wr = 0; seq_err = 0; wr_err = 0; bfu_err = 0;
    done_cyc = -1; first_cyc = -1;
    m = intt ? 1 : 0;
    for (int i = 0; i < NPAIR; i++) begin
      ca[i] = -1; cb[i] = -1; ck[i] = -1;
    end
    i_intt  = intt;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < 1100 && done_cyc < 0; cyc++) begin
      if (o_busy) busy_n++;
      if (o_bfu_intt != intt) bfu_err++;
      if (o_rd_en) begin
        if (iss == 0) first_cyc = cyc;
        if (iss < NPAIR) begin
          ca[iss] = int'(o_rd_addr_a);
          cb[iss] = int'(o_rd_addr_b);
          ck[iss] = int'(o_tw_idx);
          if (ca[iss] != ea[m][iss] || cb[iss] != eb[m][iss] || ck[iss] != ek[m][iss])
            seq_err++;
        end else begin
          seq_err++;
        end
        wq.push_back('{cyc, int'(o_rd_addr_a), int'(o_rd_addr_b)});
        iss++;
      end
      if (o_wr_en) begin
        if (wq.size() == 0) begin
          wr_err++;
        end else begin
          r = wq.pop_front();
          if (cyc != r.cyc + WR_DLY || int'(o_wr_addr_a) != r.a || int'(o_wr_addr_b) != r.b)
            wr_err++;
        end
        wr++;
      end
      if (o_done) done_cyc = cyc;
      if (disturb) begin
        i_start = (cyc == 10 || cyc == 500 || cyc == DONE_AT);
        i_intt  = ((cyc / 7) % 2 == 1) ? ~intt : intt;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    i_intt  = intt;
    chk({nm, "_idle_after_done"}, int'(o_busy), 0);
    chk({nm, "_done_cycle"}, done_cyc, DONE_AT);
    chk({nm, "_busy_cycles"}, busy_n, BUSY_N);
    chk({nm, "_first_issue_cycle"}, first_cyc, 0);
    chk({nm, "_issue_count"}, iss, NPAIR);
    chk({nm, "_wr_count"}, wr, NPAIR);
    chk({nm, "_pair_seq_errs"}, seq_err, 0);
    chk({nm, "_wr_align_errs"}, wr_err, 0);
    chk({nm, "_bfu_intt_errs"}, bfu_err, 0);
    if (!intt) begin
      chk({nm, "_first_a"}, ca[0], 0);
      chk({nm, "_first_b"}, cb[0], 128);
      chk({nm, "_first_tw"}, ck[0], 1);
      chk({nm, "_p127_a"}, ca[127], 127);
      chk({nm, "_p127_b"}, cb[127], 255);
      chk({nm, "_l7p0_a"}, ca[768], 0);
      chk({nm, "_l7p0_b"}, cb[768], 2);
      chk({nm, "_l7p0_tw"}, ck[768], 64);
    end else begin
      chk({nm, "_first_a"}, ca[0], 0);
      chk({nm, "_first_b"}, cb[0], 2);
      chk({nm, "_first_tw"}, ck[0], 127);
      chk({nm, "_last_a"}, ca[895], 127);
      chk({nm, "_last_b"}, cb[895], 255);
      chk({nm, "_last_tw"}, ck[895], 1);
    end
  endtask

  initial begin
    build_model();
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_intt  = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ctl", int'({o_busy, o_done, o_rd_en, o_wr_en, o_bfu_intt, o_bfu_skip}), 0);
    chk("rst_rd", int'({o_rd_addr_a, o_rd_addr_b, o_tw_idx}), 0);
    chk("rst_wr", int'({o_wr_addr_a, o_wr_addr_b}), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op(1'b0, 1'b0, "ntt");
    run_op(1'b1, 1'b0, "intt");
    run_op(1'b0, 1'b1, "ntt_disturb");
    run_op(1'b1, 1'b0, "intt_after_done");

    // Reset in the middle of layer 3 (pair 64: j=128, k=6)
    i_intt  = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (330) @(negedge i_clk);
    chk("mid_busy", int'(o_busy), 1);
    chk("mid_wr_en", int'(o_wr_en), 1);
    chk("mid_rd_a", int'(o_rd_addr_a), 128);
    chk("mid_tw", int'(o_tw_idx), 6);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", int'({o_busy, o_done, o_rd_en, o_wr_en, o_bfu_intt}), 0);
    chk("async_rst_rd", int'({o_rd_addr_a, o_rd_addr_b, o_tw_idx}), 0);
    chk("async_rst_wr", int'({o_wr_addr_a, o_wr_addr_b}), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_wr_en", int'(o_wr_en), 0);
    run_op(1'b0, 1'b0, "ntt_after_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
